// File: rtl/out_sig_collector_pkg.sv
// Shared types and defaults for the output signature collector.
package out_sig_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_REPORT = 2'd3
   } state_e;

   localparam logic [31:0] DEF_SIG_POLY = 32'h04C11DB7;
   localparam logic [31:0] DEF_SIG_SEED = 32'h0000_0000;

   localparam logic MODE_STREAM = 1'b0;
   localparam logic MODE_SIG    = 1'b1;

   // Width of the intermediate byte fold
   localparam int unsigned FOLD1_W = 8;

endpackage

// File: rtl/out_sig_collector_if.sv
// Kernel-side bundle of the collector: run control, channel words and reported results.
interface out_sig_collector_if #(
   parameter int unsigned DIN_W  = 32,
   parameter int unsigned NUM_CH = 1,
   parameter int unsigned DOUT_W = 4,
   parameter int unsigned CNT_W  = 16
);
   logic                     ap_start;
   logic                     ap_done;
   logic                     mode;
   logic [NUM_CH*DIN_W-1:0]  ch_din;
   logic [NUM_CH-1:0]        ch_write;
   logic [DOUT_W-1:0]        data_out;
   logic                     data_valid;
   logic [DIN_W-1:0]         sig_out;
   logic                     sig_valid;
   logic [CNT_W-1:0]         word_cnt;
   logic                     cnt_sat;

   modport master (
      output ap_start, ap_done, mode, ch_din, ch_write,
      input  data_out, data_valid, sig_out, sig_valid, word_cnt, cnt_sat
   );

   modport slave (
      input  ap_start, ap_done, mode, ch_din, ch_write,
      output data_out, data_valid, sig_out, sig_valid, word_cnt, cnt_sat
   );
endinterface

// File: rtl/out_sig_collector_xor_fold.sv
// Combinational reducer: XORs IN_W bits together in OUT_W-bit slices (top slice zero-padded).
module xor_fold #(
   parameter int unsigned IN_W  = 32,
   parameter int unsigned OUT_W = 8
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] fold_c
);
   import out_sig_pkg::*;

   localparam int unsigned N_SLICE = (IN_W + OUT_W - 1) / OUT_W;
   localparam int unsigned PAD_W   = N_SLICE * OUT_W;

   logic [PAD_W-1:0] din_pad;

   always_comb begin
      din_pad = PAD_W'(din);
      fold_c  = '0;
      for (int unsigned i = 0; i < N_SLICE; i++) begin
         fold_c = fold_c ^ din_pad[i*OUT_W +: OUT_W];
      end
   end
endmodule

// File: rtl/out_sig_collector.sv
// Compacts kernel output channels into a folded narrow stream, or a per-run MISR signature and word count.
module out_sig_collector
   import out_sig_pkg::*;
#(
   parameter int unsigned      DIN_W    = 32,
   parameter int unsigned      NUM_CH   = 1,
   parameter int unsigned      DOUT_W   = 4,
   parameter int unsigned      CNT_W    = 16,
   parameter logic [DIN_W-1:0] SIG_POLY = DIN_W'(DEF_SIG_POLY),
   parameter logic [DIN_W-1:0] SIG_SEED = DIN_W'(DEF_SIG_SEED)
) (
   input logic               ap_clk,
   input logic               ap_rst,
   out_sig_collector_if.slave bus
);
   localparam int unsigned       SUM_W   = CNT_W + 4;
   localparam logic [SUM_W-1:0]  CNT_MAX = SUM_W'({CNT_W{1'b1}});

   state_e               state_q, state_d;
   logic                 mode_q, mode_d;
   logic [DIN_W-1:0]     misr_q, misr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 sat_q, sat_d;
   logic [DIN_W-1:0]     sig_q, sig_d;
   logic                 sig_valid_q, sig_valid_d;
   logic [FOLD1_W-1:0]   fold1_q, fold1_d;
   logic                 valid1_q, valid1_d;
   logic [DOUT_W-1:0]    dout_q, dout_d;
   logic                 dvalid_q, dvalid_d;

   logic [FOLD1_W-1:0]   byte_fold_c [NUM_CH];
   logic [DOUT_W-1:0]    out_fold_c;
   logic [DIN_W-1:0]     comb_c;
   logic [DIN_W-1:0]     misr_next_c;
   logic [SUM_W-1:0]     pop_c;
   logic [SUM_W-1:0]     sum_c;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      xor_fold #(.IN_W(DIN_W), .OUT_W(FOLD1_W)) u_byte_fold (
         .din    (bus.ch_din[g*DIN_W +: DIN_W]),
         .fold_c (byte_fold_c[g])
      );
   end

   xor_fold #(.IN_W(FOLD1_W), .OUT_W(DOUT_W)) u_out_fold (
      .din    (fold1_q),
      .fold_c (out_fold_c)
   );

   // Two-stage stream fold plus per-cycle channel combine for the MISR and counter
   always_comb begin
      fold1_d = '0;
      comb_c  = '0;
      pop_c   = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (bus.ch_write[c]) begin
            fold1_d = fold1_d ^ byte_fold_c[c];
            comb_c  = comb_c ^ bus.ch_din[c*DIN_W +: DIN_W];
            pop_c   = pop_c + SUM_W'(1);
         end
      end
      valid1_d    = |bus.ch_write;
      dvalid_d    = valid1_q && (mode_q == MODE_STREAM);
      dout_d      = dvalid_d ? out_fold_c : '0;
      sum_c       = SUM_W'(cnt_q) + pop_c;
      misr_next_c = {misr_q[DIN_W-2:0], 1'b0}
                  ^ (misr_q[DIN_W-1] ? SIG_POLY : '0)
                  ^ comb_c;
   end

   // Run control; DRAIN lines the report up with the two-stage stream latency
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      misr_d      = misr_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      sig_d       = sig_q;
      sig_valid_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.ap_start) begin
               state_d = ST_RUN;
               mode_d  = bus.mode;
               misr_d  = SIG_SEED;
               cnt_d   = '0;
               sat_d   = 1'b0;
               sig_d   = '0;
            end
         end
         ST_RUN: begin
            if (valid1_d) begin
               if (mode_q == MODE_SIG) misr_d = misr_next_c;
               if (sum_c > CNT_MAX) begin
                  cnt_d = '1;
                  sat_d = 1'b1;
               end else begin
                  cnt_d = CNT_W'(sum_c);
               end
            end
            if (bus.ap_done) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            state_d = ST_REPORT;
            if (mode_q == MODE_SIG) begin
               sig_valid_d = 1'b1;
               sig_d       = misr_q;
            end
         end
         ST_REPORT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_STREAM;
         misr_q      <= SIG_SEED;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         sig_q       <= '0;
         sig_valid_q <= 1'b0;
         fold1_q     <= '0;
         valid1_q    <= 1'b0;
         dout_q      <= '0;
         dvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         misr_q      <= misr_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         sig_q       <= sig_d;
         sig_valid_q <= sig_valid_d;
         fold1_q     <= fold1_d;
         valid1_q    <= valid1_d;
         dout_q      <= dout_d;
         dvalid_q    <= dvalid_d;
      end
   end

   assign bus.data_out   = dout_q;
   assign bus.data_valid = dvalid_q;
   assign bus.sig_out    = sig_q;
   assign bus.sig_valid  = sig_valid_q;
   assign bus.word_cnt   = cnt_q;
   assign bus.cnt_sat    = sat_q;
endmodule

// File: tb/tb_out_sig_collector.sv
// Directed bench: one single-channel and one two-channel (4-bit counter) collector on a shared clock.
module tb_out_sig_collector;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   out_sig_collector_if #(.DIN_W(32), .NUM_CH(1), .DOUT_W(4), .CNT_W(16)) if1 ();
   out_sig_collector_if #(.DIN_W(32), .NUM_CH(2), .DOUT_W(4), .CNT_W(4))  if2 ();

   out_sig_collector #(.DIN_W(32), .NUM_CH(1), .DOUT_W(4), .CNT_W(16)) u1 (
      .ap_clk (clk), .ap_rst (rst), .bus (if1)
   );
   out_sig_collector #(.DIN_W(32), .NUM_CH(2), .DOUT_W(4), .CNT_W(4)) u2 (
      .ap_clk (clk), .ap_rst (rst), .bus (if2)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [63:0] din;
      logic [1:0]  wr;
      logic        exp_v;
      logic [3:0]  exp_d;
   } vec_t;

   vec_t vecs [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Arm u1 in signature mode, sign two words, end the run and check the report
   task automatic sig_run(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] exp_sig, input string nm);
      if1.mode = 1'b1; if1.ap_start = 1'b1;
      tick();
      if1.ap_start = 1'b0; if1.mode = 1'b0;
      if1.ch_din = w0; if1.ch_write = 1'b1;
      tick();
      chk({nm, " dv w0"}, 64'(if1.data_valid), 64'h0);
      if1.ch_din = w1;
      tick();
      chk({nm, " dv w1"}, 64'(if1.data_valid), 64'h0);
      if1.ch_write = 1'b0; if1.ch_din = '0; if1.ap_done = 1'b1;
      tick();
      if1.ap_done = 1'b0;
      chk({nm, " sig_valid t+1"}, 64'(if1.sig_valid), 64'h0);
      chk({nm, " dv t+1"}, 64'(if1.data_valid), 64'h0);
      tick();
      chk({nm, " sig_valid t+2"}, 64'(if1.sig_valid), 64'h1);
      chk({nm, " sig_out"}, 64'(if1.sig_out), 64'(exp_sig));
      chk({nm, " word_cnt"}, 64'(if1.word_cnt), 64'h2);
      chk({nm, " dv t+2"}, 64'(if1.data_valid), 64'h0);
      tick();
      chk({nm, " sig_valid t+3"}, 64'(if1.sig_valid), 64'h0);
      chk({nm, " sig_out hold"}, 64'(if1.sig_out), 64'(exp_sig));
   endtask

   initial begin
      vecs[0] = '{din: 64'h00000000_12345678, wr: 2'b01, exp_v: 1'b1, exp_d: 4'h8};
      vecs[1] = '{din: 64'h0000000F_12345678, wr: 2'b11, exp_v: 1'b1, exp_d: 4'h7};
      vecs[2] = '{din: 64'hFFFFFFFF_FFFFFFFF, wr: 2'b00, exp_v: 1'b0, exp_d: 4'h0};
      vecs[3] = '{din: 64'h0000000F_12345678, wr: 2'b10, exp_v: 1'b1, exp_d: 4'hF};
      vecs[4] = '{din: 64'h00000000_A5A5A5A5, wr: 2'b01, exp_v: 1'b1, exp_d: 4'h0};
      vecs[5] = '{din: 64'h00000001_000000FF, wr: 2'b11, exp_v: 1'b1, exp_d: 4'h1};
      vecs[6] = '{din: 64'h00000000_CAFEBABE, wr: 2'b01, exp_v: 1'b1, exp_d: 4'h3};
      vecs[7] = '{din: 64'h80000000_00000000, wr: 2'b10, exp_v: 1'b1, exp_d: 4'h8};

      if1.ap_start = 1'b0; if1.ap_done = 1'b0; if1.mode = 1'b0;
      if1.ch_din = '0; if1.ch_write = '0;
      if2.ap_start = 1'b0; if2.ap_done = 1'b0; if2.mode = 1'b0;
      if2.ch_din = '0; if2.ch_write = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      chk("rst u1 data_out",   64'(if1.data_out),   64'h0);
      chk("rst u1 data_valid", 64'(if1.data_valid), 64'h0);
      chk("rst u1 sig_out",    64'(if1.sig_out),    64'h0);
      chk("rst u1 sig_valid",  64'(if1.sig_valid),  64'h0);
      chk("rst u1 word_cnt",   64'(if1.word_cnt),   64'h0);
      chk("rst u1 cnt_sat",    64'(if1.cnt_sat),    64'h0);
      chk("rst u2 data_valid", 64'(if2.data_valid), 64'h0);
      chk("rst u2 word_cnt",   64'(if2.word_cnt),   64'h0);

      // Single-channel stream latency: valid only at t+2
      if1.ch_din = 32'h12345678; if1.ch_write = 1'b1;
      tick();
      if1.ch_write = 1'b0; if1.ch_din = '0;
      chk("u1 stream dv t+1", 64'(if1.data_valid), 64'h0);
      tick();
      chk("u1 stream dv t+2", 64'(if1.data_valid), 64'h1);
      chk("u1 stream do t+2", 64'(if1.data_out),   64'h8);
      tick();
      chk("u1 stream dv t+3", 64'(if1.data_valid), 64'h0);
      chk("u1 stream do t+3", 64'(if1.data_out),   64'h0);

      // Two-channel stream table, applied back to back
      for (int k = 0; k <= 8; k++) begin
         if (k < 8) begin
            if2.ch_din = vecs[k].din; if2.ch_write = vecs[k].wr;
         end else begin
            if2.ch_din = '0; if2.ch_write = '0;
         end
         tick();
         if (k >= 1) begin
            chk($sformatf("u2 vec%0d dv", k-1), 64'(if2.data_valid), 64'(vecs[k-1].exp_v));
            chk($sformatf("u2 vec%0d do", k-1), 64'(if2.data_out),   64'(vecs[k-1].exp_d));
         end
      end

      // Two-channel run in stream mode: one cycle counts both words; done beats a same-cycle start
      if2.ap_start = 1'b1; if2.mode = 1'b0;
      tick();
      if2.ap_start = 1'b0;
      if2.ch_din = 64'h0000000F_12345678; if2.ch_write = 2'b11;
      tick();
      if2.ch_write = '0;
      chk("u2 run word_cnt", 64'(if2.word_cnt), 64'h2);
      tick();
      chk("u2 run dv", 64'(if2.data_valid), 64'h1);
      chk("u2 run do", 64'(if2.data_out),   64'h7);
      if2.ap_done = 1'b1; if2.ap_start = 1'b1;
      tick();
      if2.ap_done = 1'b0; if2.ap_start = 1'b0;
      tick();
      chk("u2 stream-mode sig_valid", 64'(if2.sig_valid), 64'h0);
      tick();
      if2.ch_din = 64'h0; if2.ch_write = 2'b01;
      tick();
      if2.ch_write = '0;
      tick();
      chk("u2 idle write not counted", 64'(if2.word_cnt), 64'h2);

      // Counter saturation with a 4-bit counter, cleared on the next arm
      if2.ap_start = 1'b1;
      tick();
      if2.ap_start = 1'b0;
      for (int i = 0; i < 17; i++) begin
         if2.ch_din = 64'(i); if2.ch_write = 2'b01;
         tick();
      end
      if2.ch_write = '0; if2.ap_done = 1'b1;
      tick();
      if2.ap_done = 1'b0;
      tick();
      tick();
      chk("u2 sat word_cnt", 64'(if2.word_cnt), 64'hF);
      chk("u2 sat cnt_sat",  64'(if2.cnt_sat),  64'h1);
      if2.ap_start = 1'b1;
      tick();
      if2.ap_start = 1'b0;
      chk("u2 rearm word_cnt", 64'(if2.word_cnt), 64'h0);
      chk("u2 rearm cnt_sat",  64'(if2.cnt_sat),  64'h0);
      if2.ap_done = 1'b1;
      tick();
      if2.ap_done = 1'b0;
      tick();
      tick();

      sig_run(32'h00000001, 32'h00000001, 32'h00000003, "sig basic");
      sig_run(32'h80000000, 32'h00000000, 32'h04C11DB7, "sig feedback");

      // Reset mid-run: the run is dropped and no report follows
      if1.mode = 1'b1; if1.ap_start = 1'b1;
      tick();
      if1.ap_start = 1'b0; if1.mode = 1'b0;
      if1.ch_din = 32'h1; if1.ch_write = 1'b1;
      tick();
      if1.ch_write = 1'b0; if1.ch_din = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      if1.ap_done = 1'b1;
      tick();
      if1.ap_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst-run sig_valid c%0d", i), 64'(if1.sig_valid), 64'h0);
         tick();
      end
      chk("rst-run data_out",   64'(if1.data_out),   64'h0);
      chk("rst-run data_valid", 64'(if1.data_valid), 64'h0);
      chk("rst-run sig_out",    64'(if1.sig_out),    64'h0);
      chk("rst-run word_cnt",   64'(if1.word_cnt),   64'h0);
      chk("rst-run cnt_sat",    64'(if1.cnt_sat),    64'h0);

      sig_run(32'h00000001, 32'h00000001, 32'h00000003, "sig after rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/out_sig_collector.md
Name: out_sig_collector

Overview:
- Parametrised successor of the testbench output-compaction stage that sits between an HLS kernel's ap_fifo output port(s) and the narrow board-level data_out pins.
- Adds multi-channel input, configurable fold widths, and a signature mode.
- Stream mode: every written word is XOR-folded to DOUT_W bits with 2-cycle latency.
- Signature mode: all words for one kernel run are compressed into a MISR. The signature and word count are reported once after ap_done.

Parameters:
- DIN_W, 32: width of each channel word; multiple of 8.
- NUM_CH, 1: number of kernel output channels, 1..8.
- DOUT_W, 4: data_out width; one of 1, 2, 4, 8.
- CNT_W, 16: word counter width.
- SIG_POLY, 32'h04C11DB7: MISR feedback polynomial, DIN_W bits.
- SIG_SEED, 0: MISR value loaded at run start.

Ports:
- ap_clk, in, 1: clock.
- ap_rst, in, 1: reset.
- ap_start, in, 1: kernel start; arms a run.
- ap_done, in, 1: kernel done; ends a run.
- mode, in, 1: 0 = stream, 1 = signature; sampled on arm.
- ch_din, in, NUM_CH*DIN_W: channel words, ch0 in LSBs.
- ch_write, in, NUM_CH: per-channel write strobes.
- data_out, out, DOUT_W: folded stream word.
- data_valid, out, 1: data_out qualifier.
- sig_out, out, DIN_W: final signature.
- sig_valid, out, 1: one-cycle signature-report pulse.
- word_cnt, out, CNT_W: words accepted in the last run.
- cnt_sat, out, 1: word counter saturated in the last run.

Interface fixed: one clock; reset is synchronous and active-high (ap_clk, ap_rst).

Behaviour:
- Reset: all outputs 0, FSM IDLE, mode_q 0, MISR = SIG_SEED.
  - ap_rst mid-run drops in-flight words; no sig_valid is produced.
- Folding:
  - Stage 1 (registered): for each channel, XOR all bytes of ch_din to 8 bits. Channels whose ch_write is 0 contribute 0. XOR all channels together. valid1 = |ch_write.
  - Stage 2 (registered): XOR the 8-bit value in DOUT_W-bit slices. data_valid <= valid1 && mode_q==0. data_out <= 0 when not valid.
  - Latency: write at cycle t gives data_valid/data_out at t+2. Full throughput; the block never back-pressures (the kernel ties full_n to 1).
- FSM IDLE / RUN / DRAIN / REPORT:
  - IDLE: stream path is live with mode_q as held. On ap_start go to RUN, load mode_q<=mode, MISR<=SIG_SEED, word_cnt<=0, cnt_sat<=0.
  - RUN, on any cycle with |ch_write (including the ap_done cycle):
    - comb = XOR of valid channel words.
    - If mode_q==1: MISR <= {MISR[DIN_W-2:0],1'b0} ^ (MISR[DIN_W-1] ? SIG_POLY : 0) ^ comb.
    - word_cnt += popcount(ch_write); saturates at all-ones and sets cnt_sat. cnt_sat is sticky until the next arm.
  - RUN: ap_done goes to DRAIN. ap_start while in RUN is ignored.
  - DRAIN: one cycle, aligns with the stream pipeline. Writes here are not counted. Next state REPORT.
  - REPORT: one cycle. sig_valid=1 and sig_out=MISR only if mode_q==1; otherwise sig_valid stays 0. Next state IDLE.
- sig_out and word_cnt hold their value until the next arm.
- Timing: ap_done at cycle t gives sig_valid at t+2.
- ap_start and ap_done in the same RUN cycle: done wins; that start is ignored.
- Writes in IDLE: streamed if mode_q==0; never counted or signed.

Decomposition:
- Package out_sig_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, REPORT).
  - Default SIG_POLY and SIG_SEED.
  - Mode encodings STREAM=0, SIG=1.
- One sub-module, xor_fold #(IN_W, OUT_W): combinational slice-XOR reducer. Used for byte fold (DIN_W to 8) and output fold (8 to DOUT_W).

Test Plan:
- Stream, NUM_CH=1: mode 0, write 32'h12345678 at t -> data_valid=1 and data_out=4'h8 at t+2 only. Idle cycles give data_out=0.
- Two channels, NUM_CH=2: same-cycle writes 32'h12345678 and 32'h0000000F -> single data_out=4'h7. word_cnt increments by 2.
- Signature: arm with mode 1, write 32'h1 then 32'h1, ap_done -> sig_valid pulse 2 cycles after done, sig_out=32'h3, word_cnt=2. data_valid stays 0 throughout.
- MISR feedback: mode 1, words 32'h80000000 then 32'h0 -> sig_out=32'h04C11DB7.
- Saturation, CNT_W=4: 17 writes in one run -> word_cnt=4'hF, cnt_sat=1. Next arm clears both.
- Reset mid-run: ap_rst pulsed between writes, then ap_done -> no sig_valid, all outputs 0. A fresh run afterwards signs correctly.
